// File: rtl/cpu_pkg.sv
// Shared CPU constants and the store-unit FSM state encoding.
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 16;

   // Highest address guarded when write protection is built in.
   localparam logic [15:0] PROT_TOP_DEF = 16'h00FF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CAPT_ADDR,
      ST_CAPT_DATA,
      ST_WRITE,
      ST_FINISH
   } store_st_t;

endpackage

// File: rtl/mem_store_unit.sv
// Write-side RAM store unit. Captures an address and a data word from the
// shared bus (or derives the address from sp-1 for a stack push) and issues
// one registered RAM write per operation.
// Optional macro WRITE_PROTECT_EN: suppresses writes to addresses at or
// below PROT_TOP and reports them through the fault pulse.
module mem_store_unit
   import cpu_pkg::*;
#(
   parameter int                      DATA_W   = cpu_pkg::DATA_W,
   parameter int                      ADDR_W   = cpu_pkg::ADDR_W,
   parameter logic [ADDR_W-1:0]       PROT_TOP = ADDR_W'(cpu_pkg::PROT_TOP_DEF)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] bus,
   input  logic              start,
   input  logic              push,
   input  logic [ADDR_W-1:0] sp,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] sp_next,
   output logic              sp_load,
   output logic [ADDR_W-1:0] ram_address,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_wren,
   output logic              fault
);

   store_st_t         r_st;
   store_st_t         w_next_st;
   logic              r_busy;
   logic              r_done;
   logic              r_sp_load;
   logic              r_wren;
   logic              r_is_push;
   logic [ADDR_W-1:0] r_ram_address;
   logic [DATA_W-1:0] r_ram_data;
   logic [ADDR_W-1:0] r_sp_next;
   logic [ADDR_W-1:0] w_sp_dec;
   logic              w_prot_hit;
   logic              w_fault_flag;

   // Stack grows downward; the decrement wraps modulo 2^ADDR_W by width.
   assign w_sp_dec = sp - {{(ADDR_W-1){1'b0}}, 1'b1};

`ifdef WRITE_PROTECT_EN
   logic r_fault_flag;
   logic r_fault;

   // The address is final by the time CAPT_DATA hands over to WRITE.
   assign w_prot_hit   = (r_ram_address <= PROT_TOP);
   assign w_fault_flag = r_fault_flag;
   assign fault        = r_fault;

   // Latch the protection verdict for the operation and pulse it with done.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fault_flag <= 1'b0;
         r_fault      <= 1'b0;
      end else begin
         if (r_st == ST_CAPT_DATA) begin
            r_fault_flag <= w_prot_hit;
         end else if (r_st == ST_IDLE) begin
            r_fault_flag <= 1'b0;
         end
         r_fault <= (w_next_st == ST_FINISH) && r_fault_flag;
      end
   end
`else
   logic w_unused_prot;

   assign w_unused_prot = ^PROT_TOP;
   assign w_prot_hit    = 1'b0;
   assign w_fault_flag  = 1'b0;
   assign fault         = 1'b0;
`endif

   // Next-state sequencing; start is only honoured from IDLE.
   always_comb begin
      w_next_st = r_st;
      case (r_st)
         ST_IDLE: begin
            if (start) begin
               w_next_st = push ? ST_CAPT_DATA : ST_CAPT_ADDR;
            end
         end
         ST_CAPT_ADDR: w_next_st = ST_CAPT_DATA;
         ST_CAPT_DATA: w_next_st = ST_WRITE;
         ST_WRITE:     w_next_st = ST_FINISH;
         ST_FINISH:    w_next_st = ST_IDLE;
         default:      w_next_st = ST_IDLE;
      endcase
   end

   // State register, glitch-free registered strobes and the address/data capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_st          <= ST_IDLE;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_sp_load     <= 1'b0;
         r_wren        <= 1'b0;
         r_is_push     <= 1'b0;
         r_ram_address <= '0;
         r_ram_data    <= '0;
         r_sp_next     <= '0;
      end else begin
         r_st      <= w_next_st;
         r_busy    <= (w_next_st != ST_IDLE);
         r_wren    <= (w_next_st == ST_WRITE) && !w_prot_hit;
         r_done    <= (w_next_st == ST_FINISH);
         r_sp_load <= (w_next_st == ST_FINISH) && r_is_push && !w_fault_flag;
         case (r_st)
            ST_IDLE: begin
               if (start) begin
                  r_is_push <= push;
                  if (push) begin
                     r_ram_address <= w_sp_dec;
                     r_sp_next     <= w_sp_dec;
                  end
               end
            end
            ST_CAPT_ADDR: r_ram_address <= bus;
            ST_CAPT_DATA: r_ram_data    <= bus;
            default: ;
         endcase
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign sp_load     = r_sp_load;
   assign ram_wren    = r_wren;
   assign ram_address = r_ram_address;
   assign ram_data    = r_ram_data;
   assign sp_next     = r_sp_next;

endmodule

// File: doc/mem_store_unit.md
Name: mem_store_unit

Overview:
Write-side companion to the CPU's RAM read path. It captures a target address and a data word from the shared 16-bit bus under control-unit sequencing. It then issues a single-cycle RAM write (address, data, wren). It also supports a stack PUSH mode: the address is sp-1 taken from r8, and the unit returns the decremented stack pointer for the control unit to load back into r8.

Parameters:
DATA_W, 16, width of bus and RAM data word
ADDR_W, 16, width of RAM address
PROT_TOP, 16'h00FF, highest protected address (used only with WRITE_PROTECT_EN)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
bus  input  DATA_W  shared datapath bus (sampled, never driven)
start  input  1  one-cycle request from control unit; sampled only in IDLE
push  input  1  sampled with start: 1 = stack push, 0 = addressed store
sp  input  ADDR_W  current stack pointer (r8 output), sampled with start
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse when the operation completes
sp_next  output  ADDR_W  decremented stack pointer, valid while sp_load=1
sp_load  output  1  one-cycle pulse (same cycle as done) for a push; control unit loads r8 from sp_next
ram_address  output  ADDR_W  registered RAM address
ram_data  output  DATA_W  registered RAM write data
ram_wren  output  1  RAM write enable, exactly one cycle per operation
fault  output  1  protection-violation pulse with done (WRITE_PROTECT_EN only, else constant 0)

Behaviour:
- Reset (synchronous, rst=1 at a rising edge): state=IDLE; all outputs 0, including ram_address, ram_data, sp_next, busy, done, sp_load, ram_wren and fault.
- FSM states: IDLE, CAPT_ADDR, CAPT_DATA, WRITE, FINISH.
- IDLE, start=1, push=0: go to CAPT_ADDR.
- IDLE, start=1, push=1: ram_address <= sp-1 (mod 2^ADDR_W) and sp_next <= sp-1; go to CAPT_DATA.
- CAPT_ADDR: ram_address <= bus; go to CAPT_DATA.
- CAPT_DATA: ram_data <= bus; go to WRITE.
- WRITE: ram_wren=1 for exactly this cycle; go to FINISH.
- FINISH: done=1; sp_load=1 if the operation was a push; go to IDLE.
- Latency from the start edge:
  - addressed store: 4 cycles to done (write occurs in cycle 3);
  - push: 3 cycles to done (write occurs in cycle 2).
- start while busy is ignored; no queuing. start in the same cycle FINISH returns to IDLE is also ignored, because it is sampled only in IDLE.
- Bus sampling happens only in CAPT_ADDR and CAPT_DATA. Bus contents in other states have no effect.
- Wrap-around: sp=16'h0000 gives sp_next=ram_address=16'hFFFF. No underflow flag.
- Reset mid-operation: the unit returns to IDLE on that edge and ram_wren drops. No partial write may occur after the reset edge.
- ram_wren, done and sp_load are registered state decodes. They are glitch-free and never high for more than one consecutive cycle.
- ram_address and ram_data hold their last values in IDLE.

Optional Feature:
WRITE_PROTECT_EN
- Defined: in WRITE, if ram_address <= PROT_TOP, ram_wren stays 0 and a fault flag is set. In FINISH, fault=1 together with done. For a push, sp_load is suppressed on fault (r8 keeps its value).
- Not defined: no comparator is built; fault is tied to 0; every operation writes.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W and ADDR_W constants;
  - the store FSM state enum (ST_IDLE, ST_CAPT_ADDR, ST_CAPT_DATA, ST_WRITE, ST_FINISH);
  - the PROT_TOP default.
- No sub-module needed; the sp-1 decrementer is inline. The RAM itself stays outside the block; the datapath muxes ram_address against the fetch/stack address.

Test Plan:
1. Addressed store:
   - Stimulus: start=1, push=0; bus=16'h0200 in CAPT_ADDR; bus=16'hBEEF in CAPT_DATA.
   - Response: ram_wren=1 in cycle 3 with ram_address=16'h0200, ram_data=16'hBEEF; done=1 in cycle 4; sp_load=0.
2. Push:
   - Stimulus: sp=16'h0400, push=1; bus=16'h1234 in CAPT_DATA.
   - Response: write to 16'h03FF of 16'h1234 in cycle 2; cycle 3 has done=1, sp_load=1, sp_next=16'h03FF.
3. Wrap-around:
   - Stimulus: push with sp=16'h0000.
   - Response: ram_address=16'hFFFF and sp_next=16'hFFFF.
4. Start while busy:
   - Stimulus: start pulses in every cycle of an operation.
   - Response: exactly one ram_wren pulse and one done pulse. The next operation begins only from a start sampled in IDLE.
5. Reset mid-operation:
   - Stimulus: rst=1 in the CAPT_DATA cycle.
   - Response: next cycle busy=0; no ram_wren pulse afterward; all outputs 0.
6. WRITE_PROTECT_EN (build with macro defined):
   - Stimulus: store to 16'h0010.
   - Response: ram_wren stays 0; fault=1 and done=1 in the same cycle.
   - Stimulus: store to 16'h0100.
   - Response: write occurs and fault=0.
